arm_regfile: RTL and testbench
==============================

// Module: arm_regfile
// PURPOSE
//  - 32 x 64-bit general-purpose register file for the single-cycle ARMv8 (LEGv8) datapath.
//  - Two combinational read ports (Rn/Rm operands) and one synchronous write port (result writeback).
//  - X31 is XZR: always reads zero and ignores writes.
//  - Sits between instruction decode and the ALU/writeback mux.
// PARAMETERS
//  - N_REGS   32  number of architectural registers; the top index is XZR.
//  - WIDTH    64  register data width in bits.
//  - AW       5   address width; must satisfy 2**AW == N_REGS.
// PORTS
//  - clk    in   1      system clock; all writes on its rising edge.
//  - rst_n  in   1      asynchronous active-low reset.
//  - we3    in   1      write enable for port 3.
//  - ra1    in   5      read address, port 1.
//  - ra2    in   5      read address, port 2.
//  - wa3    in   5      write address, port 3.
//  - wd3    in   64     write data, port 3.
//  - rd1    out  64     read data, port 1 (combinational).
//  - rd2    out  64     read data, port 2 (combinational).
// BEHAVIOUR
//  - Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - Reset value: while rst_n=0, each register Xi (i=0..30) is loaded with the value i, zero-extended to 64 bits.
//    The loaded value is independent of clk. X31 has no storage.
//  - Write: on posedge clk with rst_n=1 and we3=1 and wa3!=31, wd3 is stored into X[wa3].
//    When we3=0 or wa3=31, no register changes.
//  - Read port 1: rd1 = (ra1==31) ? 0 : X[ra1]. Purely combinational, zero latency.
//  - Read port 2: rd2 follows the same rule using ra2.
//  - Write-through bypass (mandatory): if we3=1, wa3!=31 and ra==wa3, the read port returns wd3 in the same cycle.
//    A value being written is therefore visible before the clock edge; this removes the WB->ID hazard.
//  - Simultaneous events:
//    - Both read ports may address the same register, or the write register, at once; each port is independent.
//    - A write to XZR with bypass conditions met still reads 0.
//  - Reset mid-operation: reset overrides any pending write. The bypass is gated off while rst_n=0.
//    Outputs then reflect the reset contents.
//  - No X/Z on rd1/rd2 for any in-range address after reset.
// CONFIGURATION
//  - REGFILE_DEBUG_PORT_EN defined: adds input dbg_ra[4:0] and output dbg_rd[63:0].
//    dbg_rd is a third combinational read port with the same XZR rule and no bypass, for the debugger/bench dump.
//  - REGFILE_DEBUG_PORT_EN undefined: the dbg ports do not exist; behaviour is otherwise identical.
// TESTING
//  - Reset contents: pulse rst_n low, we3=0, sweep ra1=ra2=0..31 one per cycle.
//    -> rd1=rd2=i for i=0..30; rd1=rd2=0 at i=31.
//  - Write X0 with bypass: we3=1, wa3=0, wd3=255, ra1=0, ra2=25.
//    -> same cycle rd1=255, rd2=25; after the edge with we3=0, rd1 still reads 255.
//  - XZR write: we3=1, wa3=31, wd3=0xC0C0 then 0xC4C4, ra1=ra2=31.
//    -> rd1=rd2=0 on both cycles and afterwards.
//  - Write disable: we3=0, wa3=5, wd3=0xDEAD, clock edge, ra1=5.
//    -> rd1=5 (unchanged).
//  - Async reset mid-run: write X7=0x1234, then drop rst_n between edges.
//    -> rd1 (ra1=7) returns 7 immediately, without a clock edge.
//  - Dual same-address read: ra1=ra2=12 after writing X12=0xFFFF_FFFF_FFFF_FFFF.
//    -> rd1=rd2=0xFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/arm_regfile.sv
// 32 x 64-bit LEGv8 register file: two combinational read ports with write-through bypass, one synchronous write port.
// Optional third read port for debug dumps is enabled by defining REGFILE_DEBUG_PORT_EN.
module arm_regfile #(
    parameter int N_REGS = 32,
    parameter int WIDTH  = 64,
    parameter int AW     = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we3,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]    dbg_ra,
    output logic [WIDTH-1:0] dbg_rd
`else
`endif
);

    // The top index is XZR and has no storage, so only N_REGS-1 registers exist.
    localparam int          NStore = N_REGS - 1;
    localparam logic [AW-1:0] Xzr  = AW'(N_REGS - 1);

    logic [WIDTH-1:0] regs_q [NStore];
    logic [WIDTH-1:0] regs_d [NStore];
    logic             wrHit;
    logic             bypassEn;

    assign wrHit    = we3 && (wa3 != Xzr);
    assign bypassEn = rst_n && wrHit;

    always_comb begin
        regs_d = regs_q;
        if (wrHit) begin
            for (int i = 0; i < NStore; i++) begin
                if (wa3 == AW'(i)) begin
                    regs_d[i] = wd3;
                end
            end
        end
    end

    // Reset loads each register with its own index so a fresh file is easy to recognise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NStore; i++) begin
                regs_q[i] <= WIDTH'(i);
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 0; i < NStore; i++) begin
            if (ra1 == AW'(i)) begin
                rd1 = regs_q[i];
            end
            if (ra2 == AW'(i)) begin
                rd2 = regs_q[i];
            end
        end
        // Bypass can never hit XZR because wrHit already excludes it.
        if (bypassEn && (ra1 == wa3)) begin
            rd1 = wd3;
        end
        if (bypassEn && (ra2 == wa3)) begin
            rd2 = wd3;
        end
    end

`ifdef REGFILE_DEBUG_PORT_EN
    always_comb begin
        dbg_rd = '0;
        for (int i = 0; i < NStore; i++) begin
            if (dbg_ra == AW'(i)) begin
                dbg_rd = regs_q[i];
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_arm_regfile.sv
// Self-checking bench for arm_regfile: directed scenarios plus a randomized run against an array model.
module tb_arm_regfile;

    logic        clk;
    logic        rst_n;
    logic        we3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa3;
    logic [63:0] wd3;
    logic [63:0] rd1;
    logic [63:0] rd2;
`ifdef REGFILE_DEBUG_PORT_EN
    logic [4:0]  dbg_ra;
    logic [63:0] dbg_rd;
`endif

    int compared;
    int mismatched;

    // Architectural state: index 31 is XZR and always stays zero.
    logic [63:0] model [32];

    arm_regfile dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we3   (we3),
        .ra1   (ra1),
        .ra2   (ra2),
        .wa3   (wa3),
        .wd3   (wd3),
        .rd1   (rd1),
        .rd2   (rd2)
`ifdef REGFILE_DEBUG_PORT_EN
        ,
        .dbg_ra(dbg_ra),
        .dbg_rd(dbg_rd)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 31; i++) model[i] = 64'(i);
        model[31] = 64'd0;
    endtask

    // Expected architectural read including the same-cycle write visibility rule.
    function automatic logic [63:0] expRead(input logic [4:0] ra);
        if (ra == 5'd31) return 64'd0;
        if (rst_n && we3 && wa3 != 5'd31 && wa3 == ra) return wd3;
        return model[ra];
    endfunction

    // Advance one clock edge and commit any write to the model; returns 1 ns after the edge.
    task automatic tick();
        logic       doWr;
        logic [4:0] a;
        logic [63:0] d;
        doWr = rst_n && we3 && (wa3 != 5'd31);
        a = wa3;
        d = wd3;
        @(posedge clk);
        if (doWr) model[a] = d;
        #1;
    endtask

    task automatic test_reset();
        we3 = 1'b0; wa3 = '0; wd3 = '0; ra1 = '0; ra2 = '0;
        rst_n = 1'b0;
        modelReset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            logic [63:0] want;
            ra1 = 5'(i);
            ra2 = 5'(i);
            want = (i == 31) ? 64'd0 : 64'(i);
            #1;
            compared++;
            if (rd1 !== want) begin
                mismatched++;
                $display("[TB] FAIL reset_rd1 X%0d: got %h expected %h", i, rd1, want);
            end
            compared++;
            if (rd2 !== want) begin
                mismatched++;
                $display("[TB] FAIL reset_rd2 X%0d: got %h expected %h", i, rd2, want);
            end
            tick();
        end
    endtask

    task automatic test_bypass_x0();
        we3 = 1'b1; wa3 = 5'd0; wd3 = 64'd255; ra1 = 5'd0; ra2 = 5'd25;
        #1;
        compared++;
        if (rd1 !== 64'd255) begin
            mismatched++;
            $display("[TB] FAIL bypass_rd1: got %h expected %h", rd1, 64'd255);
        end
        compared++;
        if (rd2 !== 64'd25) begin
            mismatched++;
            $display("[TB] FAIL bypass_rd2: got %h expected %h", rd2, 64'd25);
        end
        tick();
        we3 = 1'b0;
        #1;
        compared++;
        if (rd1 !== 64'd255) begin
            mismatched++;
            $display("[TB] FAIL x0_after_edge: got %h expected %h", rd1, 64'd255);
        end
    endtask

    task automatic test_xzr();
        logic [63:0] vals [2];
        vals[0] = 64'hC0C0;
        vals[1] = 64'hC4C4;
        ra1 = 5'd31; ra2 = 5'd31; wa3 = 5'd31; we3 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k < 2) wd3 = vals[k];
            else we3 = 1'b0;
            #1;
            compared++;
            if (rd1 !== 64'd0) begin
                mismatched++;
                $display("[TB] FAIL xzr_rd1 step%0d: got %h expected 0", k, rd1);
            end
            compared++;
            if (rd2 !== 64'd0) begin
                mismatched++;
                $display("[TB] FAIL xzr_rd2 step%0d: got %h expected 0", k, rd2);
            end
            tick();
        end
    endtask

    task automatic test_write_disable();
        we3 = 1'b0; wa3 = 5'd5; wd3 = 64'hDEAD; ra1 = 5'd5; ra2 = 5'd6;
        tick();
        #1;
        compared++;
        if (rd1 !== 64'd5) begin
            mismatched++;
            $display("[TB] FAIL write_disable: got %h expected %h", rd1, 64'd5);
        end
    endtask

    task automatic test_async_reset();
        we3 = 1'b1; wa3 = 5'd7; wd3 = 64'h1234; ra1 = 5'd7; ra2 = 5'd0;
        tick();
        we3 = 1'b0;
        #1;
        compared++;
        if (rd1 !== 64'h1234) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_x7: got %h expected %h", rd1, 64'h1234);
        end
        // Pending write to X7 while reset is low must neither bypass nor commit.
        #1;
        we3 = 1'b1; wd3 = 64'hBEEF;
        rst_n = 1'b0;
        modelReset();
        #1;
        compared++;
        if (rd1 !== 64'd7) begin
            mismatched++;
            $display("[TB] FAIL async_reset_x7: got %h expected %h", rd1, 64'd7);
        end
        compared++;
        if (rd2 !== 64'd0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_x0: got %h expected %h", rd2, 64'd0);
        end
        tick();
        compared++;
        if (rd1 !== 64'd7) begin
            mismatched++;
            $display("[TB] FAIL reset_blocks_write: got %h expected %h", rd1, 64'd7);
        end
        we3 = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_dual_read();
        we3 = 1'b1; wa3 = 5'd12; wd3 = 64'hFFFF_FFFF_FFFF_FFFF; ra1 = 5'd3; ra2 = 5'd4;
        tick();
        we3 = 1'b0; ra1 = 5'd12; ra2 = 5'd12;
        #1;
        compared++;
        if (rd1 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            mismatched++;
            $display("[TB] FAIL dual_rd1: got %h expected all-ones", rd1);
        end
        compared++;
        if (rd2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            mismatched++;
            $display("[TB] FAIL dual_rd2: got %h expected all-ones", rd2);
        end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [63:0] e1;
            logic [63:0] e2;
            we3 = 1'($urandom_range(0, 1));
            wa3 = 5'($urandom_range(0, 31));
            wd3 = {$urandom, $urandom};
            ra1 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa3 : 5'($urandom_range(0, 31));
`ifdef REGFILE_DEBUG_PORT_EN
            dbg_ra = 5'($urandom_range(0, 31));
`endif
            #1;
            e1 = expRead(ra1);
            e2 = expRead(ra2);
            compared++;
            if (rd1 !== e1) begin
                mismatched++;
                $display("[TB] FAIL rand_rd1 n=%0d ra1=%0d: got %h expected %h", n, ra1, rd1, e1);
            end
            compared++;
            if (rd2 !== e2) begin
                mismatched++;
                $display("[TB] FAIL rand_rd2 n=%0d ra2=%0d: got %h expected %h", n, ra2, rd2, e2);
            end
`ifdef REGFILE_DEBUG_PORT_EN
            compared++;
            if (dbg_rd !== model[dbg_ra]) begin
                mismatched++;
                $display("[TB] FAIL rand_dbg n=%0d: got %h expected %h", n, dbg_rd, model[dbg_ra]);
            end
`endif
            tick();
        end
        we3 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ra1 = 5'(i);
            #1;
            compared++;
            if (rd1 !== model[i]) begin
                mismatched++;
                $display("[TB] FAIL final_dump X%0d: got %h expected %h", i, rd1, model[i]);
            end
        end
    endtask

    initial begin
        compared = 0;
        mismatched = 0;
        rst_n = 1'b0;
        we3 = 1'b0; ra1 = '0; ra2 = '0; wa3 = '0; wd3 = '0;
`ifdef REGFILE_DEBUG_PORT_EN
        dbg_ra = '0;
`endif
        modelReset();
        test_reset();
        test_bypass_x0();
        test_xzr();
        test_write_disable();
        test_async_reset();
        test_dual_read();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
